// File: rtl/alu_src_ctrl.sv
// Multicycle operand-sequencing controller: steps each instruction through
// fetch/decode/execute/memory/write-back and drives ALU selects and write enables.
module alu_src_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       wb_sel,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

  logic [3:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next;
  logic       w_last;
  logic       w_funct_ok;
  logic [2:0] w_r_ctrl;
  logic       w_taken;

  assign w_last  = (r_cnt == LAST_CNT);
  assign w_taken = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);

  always_comb begin
    w_funct_ok = 1'b1;
    w_r_ctrl   = ALU_ADD;
    case (funct)
      FN_ADD:  w_r_ctrl = ALU_ADD;
      FN_SUB:  w_r_ctrl = ALU_SUB;
      FN_AND:  w_r_ctrl = ALU_AND;
      FN_OR:   w_r_ctrl = ALU_OR;
      FN_SLT:  w_r_ctrl = ALU_SLT;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_next = w_funct_ok ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI:       w_next = S_EXEC_I;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          default:       w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = w_last ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   w_next = w_last ? S_FETCH : S_MEM_WR;
      default:    w_next = S_FETCH;
    endcase
  end

  // cnt only advances while a memory state holds; any transition restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  always_comb begin
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_IDLE;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    wb_sel        = 1'b0;
    illegal       = 1'b0;
    state         = 4'd0;
    // Outputs are forced quiet while reset is high so no write can slip through.
    if (!reset) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_write  = w_last;
          pc_write  = w_last;
        end
        S_DECODE: begin
          alu_src_b     = 2'b11;
          alu_ctrl      = ALU_ADD;
          ab_write      = 1'b1;
          alu_out_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a     = 1'b1;
          alu_ctrl      = w_r_ctrl;
          alu_out_write = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b10;
          alu_ctrl      = ALU_ADD;
          alu_out_write = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_MEM_RD: begin
          mem_rd    = 1'b1;
          iord      = 1'b1;
          mdr_write = w_last;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 1'b1;
          pc_write  = w_taken;
        end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_src_ctrl.sv
// Bench for alu_src_ctrl: table of instructions expanded into per-cycle expected
// output words on a scoreboard queue, plus a reset-during-store sequence.
module tb_alu_src_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset3, zero;
  logic [5:0] opcode, funct;

  logic       a_a, m_rd, m_wr, io, irw, mdrw, abw, aow, pcw, pcs, rw, rdst, wbs, ill;
  logic [1:0] a_b;
  logic [2:0] ac;
  logic [3:0] st;
  logic       a_a3, m_rd3, m_wr3, io3, irw3, mdrw3, abw3, aow3, pcw3, pcs3, rw3, rdst3, wbs3;
  logic       ill3;
  logic [1:0] a_b3;
  logic [2:0] ac3;
  logic [3:0] st3;

  alu_src_ctrl #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_src_a(a_a), .alu_src_b(a_b), .alu_ctrl(ac), .mem_rd(m_rd), .mem_wr(m_wr),
    .iord(io), .ir_write(irw), .mdr_write(mdrw), .ab_write(abw), .alu_out_write(aow),
    .pc_write(pcw), .pc_src(pcs), .reg_write(rw), .reg_dst(rdst), .wb_sel(wbs),
    .illegal(ill), .state(st)
  );

  alu_src_ctrl #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset3), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_src_a(a_a3), .alu_src_b(a_b3), .alu_ctrl(ac3), .mem_rd(m_rd3), .mem_wr(m_wr3),
    .iord(io3), .ir_write(irw3), .mdr_write(mdrw3), .ab_write(abw3), .alu_out_write(aow3),
    .pc_write(pcw3), .pc_src(pcs3), .reg_write(rw3), .reg_dst(rdst3), .wb_sel(wbs3),
    .illegal(ill3), .state(st3)
  );

  // Word: {state, src_a, src_b, alu_ctrl, mem_rd, mem_wr, iord, ir_write, mdr_write,
  //        ab_write, alu_out_write, pc_write, pc_src, reg_write, reg_dst, wb_sel, illegal}
  logic [22:0] act2, act3;
  assign act2 = {st, a_a, a_b, ac, m_rd, m_wr, io, irw, mdrw, abw, aow, pcw, pcs, rw, rdst,
                 wbs, ill};
  assign act3 = {st3, a_a3, a_b3, ac3, m_rd3, m_wr3, io3, irw3, mdrw3, abw3, aow3, pcw3, pcs3,
                 rw3, rdst3, wbs3, ill3};

  localparam int CLS_R = 0, CLS_I = 1, CLS_LW = 2, CLS_SW = 3, CLS_BR = 4, CLS_ILL = 5;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cls;
    logic [2:0] ctrl;
    logic       taken;
    int         cycles;
  } vec_t;

  vec_t        tbl[15];
  logic [22:0] q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [22:0] w(input logic [3:0] s, input logic a, input logic [1:0] b,
                                    input logic [2:0] c, input logic [12:0] f);
    return {s, a, b, c, f};
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_instr(input int cls, input logic [2:0] ctrl, input logic taken,
                            input int wt);
    for (int i = 0; i < wt; i++)
      q.push_back(w(4'd0, 1'b0, 2'b01, 3'b001, (i == wt - 1) ? 13'h1220 : 13'h1000));
    q.push_back(w(4'd1, 1'b0, 2'b11, 3'b001, 13'h00C0));
    case (cls)
      CLS_R: begin
        q.push_back(w(4'd2, 1'b1, 2'b00, ctrl, 13'h0040));
        q.push_back(w(4'd3, 1'b0, 2'b00, 3'b000, 13'h000C));
      end
      CLS_I: begin
        q.push_back(w(4'd4, 1'b1, 2'b10, 3'b001, 13'h0040));
        q.push_back(w(4'd5, 1'b0, 2'b00, 3'b000, 13'h0008));
      end
      CLS_LW: begin
        q.push_back(w(4'd6, 1'b1, 2'b10, 3'b001, 13'h0040));
        for (int i = 0; i < wt; i++)
          q.push_back(w(4'd7, 1'b0, 2'b00, 3'b000, (i == wt - 1) ? 13'h1500 : 13'h1400));
        q.push_back(w(4'd8, 1'b0, 2'b00, 3'b000, 13'h000A));
      end
      CLS_SW: begin
        q.push_back(w(4'd6, 1'b1, 2'b10, 3'b001, 13'h0040));
        for (int i = 0; i < wt; i++) q.push_back(w(4'd9, 1'b0, 2'b00, 3'b000, 13'h0C00));
      end
      CLS_BR: q.push_back(w(4'd10, 1'b1, 2'b00, 3'b010, taken ? 13'h0030 : 13'h0010));
      default: q.push_back(w(4'd11, 1'b0, 2'b00, 3'b000, 13'h0001));
    endcase
  endtask

  // Pops one expected word per cycle; an empty queue compares against X and fails.
  task automatic drain(input bit sel, input int n, input string name);
    logic [22:0] exp;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp = (q.size() > 0) ? q.pop_front() : 23'bx;
      check(name, sel ? act3 : act2, exp);
    end
  endtask

  task automatic end_check(input bit sel, input string name);
    logic [22:0] got;
    @(posedge clk);
    #1;
    got = sel ? act3 : act2;
    checks++;
    if (got[22:19] !== 4'd0 || got[12] !== 1'b1) begin
      errors++;
      $display("FAIL %s_next_fetch: got state %0d mem_rd %b expected state 0 mem_rd 1", name,
               got[22:19], got[12]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    reset3 = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    tbl[0]  = '{6'h00, 6'h20, 1'b0, CLS_R,   3'b001, 1'b0, 5};
    tbl[1]  = '{6'h00, 6'h22, 1'b1, CLS_R,   3'b010, 1'b0, 5};
    tbl[2]  = '{6'h00, 6'h24, 1'b0, CLS_R,   3'b011, 1'b0, 5};
    tbl[3]  = '{6'h00, 6'h25, 1'b0, CLS_R,   3'b100, 1'b0, 5};
    tbl[4]  = '{6'h00, 6'h2A, 1'b0, CLS_R,   3'b111, 1'b0, 5};
    tbl[5]  = '{6'h08, 6'h22, 1'b0, CLS_I,   3'b001, 1'b0, 5};
    tbl[6]  = '{6'h23, 6'h2A, 1'b0, CLS_LW,  3'b001, 1'b0, 7};
    tbl[7]  = '{6'h2B, 6'h20, 1'b1, CLS_SW,  3'b001, 1'b0, 6};
    tbl[8]  = '{6'h04, 6'h00, 1'b1, CLS_BR,  3'b010, 1'b1, 4};
    tbl[9]  = '{6'h04, 6'h00, 1'b0, CLS_BR,  3'b010, 1'b0, 4};
    tbl[10] = '{6'h05, 6'h00, 1'b0, CLS_BR,  3'b010, 1'b1, 4};
    tbl[11] = '{6'h05, 6'h00, 1'b1, CLS_BR,  3'b010, 1'b0, 4};
    tbl[12] = '{6'h3F, 6'h20, 1'b0, CLS_ILL, 3'b000, 1'b0, 4};
    tbl[13] = '{6'h00, 6'h00, 1'b0, CLS_ILL, 3'b000, 1'b0, 4};
    tbl[14] = '{6'h02, 6'h20, 1'b0, CLS_ILL, 3'b000, 1'b0, 4};

    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", act2, 23'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      opcode = tbl[i].op;
      funct  = tbl[i].fn;
      zero   = tbl[i].z;
      push_instr(tbl[i].cls, tbl[i].ctrl, tbl[i].taken, 2);
      drain(1'b0, tbl[i].cycles, $sformatf("vec%0d", i));
      end_check(1'b0, $sformatf("vec%0d", i));
    end

    // sw with W=3, reset raised in the second MEM_WR cycle.
    opcode = 6'h2B;
    funct  = 6'h00;
    zero   = 1'b0;
    @(posedge clk);
    #1 reset3 = 1'b0;
    push_instr(CLS_SW, 3'b001, 1'b0, 3);
    drain(1'b1, 6, "sw_pre_abort");
    q.delete();
    @(posedge clk);
    #1 reset3 = 1'b1;
    @(negedge clk);
    check("rst_mid_memwr", act3, 23'd0);
    @(posedge clk);
    #1 reset3 = 1'b0;
    push_instr(CLS_SW, 3'b001, 1'b0, 3);
    drain(1'b1, 8, "sw_after_abort");
    end_check(1'b1, "sw_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_src_ctrl.md
# alu_src_ctrl

Multicycle operand-sequencing controller for the MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and write-back. In every cycle it drives the ALU operand-select lines: A source, and the 2-bit B selector that picks register B, constant 4, sign-extended immediate or shifted immediate. It also drives the matching ALU operation and the register/memory write enables. It sits between the instruction register and the ALU input multiplexers. It is the producer of the selector codes that those multiplexers consume.

## Interface
- MEM_WAIT, default 2: cycles a memory access is held (fetch, load, store); legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag of the current cycle.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_ctrl  out  3  001 add, 010 sub, 011 and, 100 or, 111 slt, 000 idle.
- mem_rd, mem_wr, iord  out  1 each  memory read, memory write, address source (0 = PC, 1 = ALUOut).
- ir_write, mdr_write, ab_write, alu_out_write  out  1 each  register load enables.
- pc_write  out  1  PC load; pc_src  out  1  0 = ALU result, 1 = ALUOut.
- reg_write, reg_dst, wb_sel  out  1 each  regfile write; dest 1 = rd, 0 = rt; data 0 = ALUOut, 1 = MDR.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- state  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, ILLEGAL. 4-bit wait counter `cnt`.
- Outputs are Moore, decoded from state. The one exception is pc_write in BRANCH. Any output not listed for a state is 0.
- FETCH:
  - Drives mem_rd=1, iord=0, src_a=0, src_b=01, alu_ctrl=add.
  - `cnt` counts 0..MEM_WAIT-1.
  - On the last count it also drives ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- DECODE:
  - Drives src_a=0, src_b=11, add, ab_write=1, alu_out_write=1.
  - Next state by opcode:
    - 0x00 with funct 0x20/0x22/0x24/0x25/0x2A → EXEC_R.
    - 0x08 → EXEC_I.
    - 0x23 or 0x2B → MEM_ADDR.
    - 0x04 or 0x05 → BRANCH.
    - Anything else → ILLEGAL.
- EXEC_R: src_a=1, src_b=00, alu_ctrl from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), alu_out_write=1 → WB_R.
- WB_R: reg_write=1, reg_dst=1, wb_sel=0 → FETCH.
- EXEC_I: src_a=1, src_b=10, add, alu_out_write=1 → WB_I.
- WB_I: reg_write=1, reg_dst=0, wb_sel=0 → FETCH.
- MEM_ADDR: src_a=1, src_b=10, add, alu_out_write=1 → MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_rd=1, iord=1 for MEM_WAIT cycles; mdr_write=1 on the last → WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, wb_sel=1 → FETCH.
- MEM_WR: mem_wr=1, iord=1 for MEM_WAIT cycles → FETCH.
- BRANCH:
  - Drives src_a=1, src_b=00, sub, pc_src=1.
  - pc_write = (opcode==0x04 & zero) | (opcode==0x05 & ~zero), combinational in this state.
  - → FETCH.
- ILLEGAL: illegal=1 → FETCH. No register or memory writes.
- opcode/funct are sampled only in DECODE, EXEC_R, MEM_ADDR and BRANCH; the IR holds them stable there.

## Timing
- While reset is high, all outputs are 0 (alu_src_b=00, alu_ctrl=000, state=0).
- On the first clk edge with reset high, state becomes FETCH and `cnt` becomes 0.
- Reset asserted mid-instruction aborts it at the next edge. No write enable may be high in the cycle reset is sampled.
- Cycles per instruction, with W = MEM_WAIT:
  - R-type, addi: W+3.
  - lw: 2W+3.
  - sw: 2W+2.
  - beq/bne: W+2.
  - Illegal: W+2.
- `cnt` clears on every state change. MEM_WAIT=1 means a single-cycle access with its enable on that cycle.
- Each write enable is high for exactly one cycle per instruction. mem_wr is the exception: it stays high for all W cycles.
- alu_src_b is never 01 outside FETCH and never 11 outside DECODE.

## Test plan
- Reset held 3 cycles, then released → outputs all 0 during reset. First post-reset cycle: state=FETCH, mem_rd=1, src_b=01.
- add (op 0x00, funct 0x20), W=2 → src_b sequence 01,01,11,00,xx. ir_write in cycle 2, reg_write=1 with reg_dst=1 in cycle 5. Next FETCH in cycle 6.
- lw (0x23), W=2 → src_b=10 in MEM_ADDR. mem_rd+iord for 2 cycles, mdr_write on the second. WB_MEM has wb_sel=1. 7 cycles total.
- beq with zero=1 then zero=0; bne with zero=0 → pc_write=1 and pc_src=1 in BRANCH for the taken cases, pc_write=0 otherwise. 4 cycles each.
- opcode 0x3F, then R-type funct 0x00 → illegal pulses 1 cycle and returns to FETCH. No reg_write/mem_wr in either instruction.
- reset asserted during MEM_WR of sw (W=3, 2nd wait cycle) → mem_wr=0 in the reset cycle. FETCH with cnt=0 after release.
